// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_ctrl
//  Description : Fetch-side flow control. Owns the fetch PC, issues Icache
//                requests under a credit limit, drops responses made stale
//                by a redirect, and buffers instructions in order for if_id.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MAX_OUT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fc_jump_flag_i,
   input  logic [31:0] fc_jump_pc_i,
   input  logic        fc_stall_flag_i,
   output logic        if_req_valid_o,
   output logic [31:0] if_req_pc_o,
   input  logic        Icache_ready_i,
   input  logic        Icache_rsp_valid_i,
   input  logic [31:0] Icache_rsp_inst_i,
   output logic        if_valid_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
   output logic        if_err_o
);

   localparam int             CW       = $clog2(MAX_OUT + 1);
   localparam int             PW       = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam logic [CW:0]    CREDIT   = (CW + 1)'(MAX_OUT);
   localparam logic [PW-1:0]  PTR_LAST = PW'(MAX_OUT - 1);

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] kill_q, kill_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic          err_q, err_d;

   logic [31:0]   pcq_mem_q [MAX_OUT];
   logic [31:0]   pcq_mem_d [MAX_OUT];
   logic [PW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;

   logic [31:0]   out_pc_q   [MAX_OUT];
   logic [31:0]   out_pc_d   [MAX_OUT];
   logic [31:0]   out_inst_q [MAX_OUT];
   logic [31:0]   out_inst_d [MAX_OUT];
   logic [PW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
   logic [31:0]   last_pc_q, last_pc_d, last_inst_q, last_inst_d;

   logic w_req_valid, w_accept, w_rsp_ok, w_rsp_keep, w_pop;

   // Credit counts both in-flight requests and buffered entries, so the out
   // FIFO always has room for every response that can still arrive.
   assign w_req_valid = !rst && !fc_jump_flag_i && !fc_stall_flag_i &&
                        (({1'b0, inflight_q} + {1'b0, out_cnt_q}) < CREDIT);
   assign w_accept    = w_req_valid && Icache_ready_i;
   assign w_rsp_ok    = Icache_rsp_valid_i && (inflight_q != '0);
   assign w_rsp_keep  = w_rsp_ok && (kill_q == '0) && !fc_jump_flag_i;
   assign w_pop       = (out_cnt_q != '0) && !fc_stall_flag_i && !fc_jump_flag_i;

   always_comb begin
      pc_d        = pc_q;
      inflight_d  = inflight_q + CW'(w_accept) - CW'(w_rsp_ok);
      kill_d      = kill_q;
      out_cnt_d   = out_cnt_q + CW'(w_rsp_keep) - CW'(w_pop);
      err_d       = err_q;
      pcq_mem_d   = pcq_mem_q;
      pcq_wr_d    = pcq_wr_q;
      pcq_rd_d    = pcq_rd_q;
      out_pc_d    = out_pc_q;
      out_inst_d  = out_inst_q;
      out_wr_d    = out_wr_q;
      out_rd_d    = out_rd_q;
      last_pc_d   = last_pc_q;
      last_inst_d = last_inst_q;

      if (w_accept) begin
         pc_d                = pc_q + 32'd4;
         pcq_mem_d[pcq_wr_q] = pc_q;
         pcq_wr_d            = ptr_inc(pcq_wr_q);
      end
      if (w_rsp_ok) begin
         pcq_rd_d = ptr_inc(pcq_rd_q);
         if (kill_q != '0) kill_d = kill_q - 1'b1;
      end
      if (Icache_rsp_valid_i && (inflight_q == '0)) err_d = 1'b1;
      if (w_rsp_keep) begin
         out_pc_d[out_wr_q]   = pcq_mem_q[pcq_rd_q];
         out_inst_d[out_wr_q] = Icache_rsp_inst_i;
         out_wr_d             = ptr_inc(out_wr_q);
      end
      if (w_pop) begin
         last_pc_d   = out_pc_q[out_rd_q];
         last_inst_d = out_inst_q[out_rd_q];
         out_rd_d    = ptr_inc(out_rd_q);
      end
      // Redirect: everything still in flight becomes stale, buffer is flushed.
      if (fc_jump_flag_i) begin
         pc_d        = {fc_jump_pc_i[31:2], 2'b00};
         kill_d      = inflight_q - CW'(w_rsp_ok);
         out_cnt_d   = '0;
         out_wr_d    = '0;
         out_rd_d    = '0;
         last_inst_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         inflight_q  <= '0;
         kill_q      <= '0;
         out_cnt_q   <= '0;
         err_q       <= 1'b0;
         pcq_wr_q    <= '0;
         pcq_rd_q    <= '0;
         out_wr_q    <= '0;
         out_rd_q    <= '0;
         last_pc_q   <= '0;
         last_inst_q <= '0;
      end else begin
         pc_q        <= pc_d;
         inflight_q  <= inflight_d;
         kill_q      <= kill_d;
         out_cnt_q   <= out_cnt_d;
         err_q       <= err_d;
         pcq_wr_q    <= pcq_wr_d;
         pcq_rd_q    <= pcq_rd_d;
         out_wr_q    <= out_wr_d;
         out_rd_q    <= out_rd_d;
         last_pc_q   <= last_pc_d;
         last_inst_q <= last_inst_d;
      end
      pcq_mem_q  <= pcq_mem_d;
      out_pc_q   <= out_pc_d;
      out_inst_q <= out_inst_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (kill_q <= inflight_q);
   end

   assign if_req_valid_o = w_req_valid;
   assign if_req_pc_o    = pc_q;
   assign if_valid_o     = (out_cnt_q != '0);
   assign if_pc_o        = if_valid_o ? out_pc_q[out_rd_q]   : last_pc_q;
   assign if_inst_o      = if_valid_o ? out_inst_q[out_rd_q] : last_inst_q;
   assign if_err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_ctrl
//  Description : Randomised and directed bench for if_fetch_ctrl against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_ctrl;

   localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
   localparam int          C_MAX_OUT  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        fc_jump_flag_i;
   logic [31:0] fc_jump_pc_i;
   logic        fc_stall_flag_i;
   logic        if_req_valid_o;
   logic [31:0] if_req_pc_o;
   logic        Icache_ready_i;
   logic        Icache_rsp_valid_i;
   logic [31:0] Icache_rsp_inst_i;
   logic        if_valid_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        if_err_o;

   if_fetch_ctrl #(.RESET_PC(C_RESET_PC), .MAX_OUT(C_MAX_OUT)) dut (
      .clk                (clk),
      .rst                (rst),
      .fc_jump_flag_i     (fc_jump_flag_i),
      .fc_jump_pc_i       (fc_jump_pc_i),
      .fc_stall_flag_i    (fc_stall_flag_i),
      .if_req_valid_o     (if_req_valid_o),
      .if_req_pc_o        (if_req_pc_o),
      .Icache_ready_i     (Icache_ready_i),
      .Icache_rsp_valid_i (Icache_rsp_valid_i),
      .Icache_rsp_inst_i  (Icache_rsp_inst_i),
      .if_valid_o         (if_valid_o),
      .if_pc_o            (if_pc_o),
      .if_inst_o          (if_inst_o),
      .if_err_o           (if_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      bit          stale;
   } fl_t;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   // Reference model state
   fl_t         m_fl[$];
   ent_t        m_out[$];
   logic [31:0] m_pc;
   logic [31:0] m_last_pc;
   logic [31:0] m_last_inst;
   bit          m_err;
   bit          m_known = 0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive at negedge, check the model, then advance the model on
   // the rising edge using the same inputs the DUT saw.
   task automatic cycle(input bit r, input bit j, input logic [31:0] jpc, input bit st,
                        input bit rdy, input bit rv, input logic [31:0] ri);
      bit   exp_rv, acc, pop;
      ent_t e;
      fl_t  f;
      rst                = r;
      fc_jump_flag_i     = j;
      fc_jump_pc_i       = jpc;
      fc_stall_flag_i    = st;
      Icache_ready_i     = rdy;
      Icache_rsp_valid_i = rv;
      Icache_rsp_inst_i  = ri;
      #1;
      exp_rv = !r && !j && !st && ((m_fl.size() + m_out.size()) < C_MAX_OUT);
      if (m_known) begin
         chk("req_valid", {31'd0, if_req_valid_o}, {31'd0, exp_rv});
         chk("req_pc", if_req_pc_o, m_pc);
         chk("if_valid", {31'd0, if_valid_o}, {31'd0, m_out.size() != 0});
         chk("if_pc", if_pc_o, (m_out.size() != 0) ? m_out[0].pc : m_last_pc);
         chk("if_inst", if_inst_o, (m_out.size() != 0) ? m_out[0].inst : m_last_inst);
         chk("if_err", {31'd0, if_err_o}, {31'd0, m_err});
      end
      @(posedge clk);
      if (r) begin
         m_fl.delete();
         m_out.delete();
         m_pc        = C_RESET_PC;
         m_last_pc   = '0;
         m_last_inst = '0;
         m_err       = 0;
         m_known     = 1;
      end else begin
         acc = exp_rv && rdy;
         pop = (m_out.size() != 0) && !st && !j;
         if (pop) begin
            e           = m_out.pop_front();
            m_last_pc   = e.pc;
            m_last_inst = e.inst;
         end
         if (rv) begin
            if (m_fl.size() == 0) m_err = 1;
            else begin
               f = m_fl.pop_front();
               if (!f.stale && !j) begin
                  e.pc   = f.pc;
                  e.inst = ri;
                  m_out.push_back(e);
               end
            end
         end
         if (acc) begin
            f.pc    = m_pc;
            f.stale = 0;
            m_fl.push_back(f);
            m_pc = m_pc + 32'd4;
         end
         if (j) begin
            foreach (m_fl[k]) m_fl[k].stale = 1;
            m_out.delete();
            m_last_inst = '0;
            m_pc        = {jpc[31:2], 2'b00};
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input bit rdy, input bit rv, input logic [31:0] ri);
      cycle(0, 0, 32'd0, 0, rdy, rv, ri);
   endtask

   task automatic do_reset();
      cycle(1, 0, 32'd0, 0, 1, 0, 32'd0);
      cycle(1, 0, 32'd0, 0, 1, 0, 32'd0);
   endtask

   logic [31:0] held_pc, held_inst;

   initial begin
      rst = 1; fc_jump_flag_i = 0; fc_jump_pc_i = 0; fc_stall_flag_i = 0;
      Icache_ready_i = 0; Icache_rsp_valid_i = 0; Icache_rsp_inst_i = 0;
      @(negedge clk);

      // Reset values and in-order fetch with one-cycle responses
      do_reset();
      chk("rst_if_valid", {31'd0, if_valid_o}, 32'd0);
      chk("rst_if_pc", if_pc_o, 32'd0);
      chk("rst_if_inst", if_inst_o, 32'd0);
      chk("rst_req_pc", if_req_pc_o, 32'h0);
      idle(1, 0, 32'd0);
      chk("t1_req_pc", if_req_pc_o, 32'h4);
      idle(1, 1, 32'hA0);
      chk("t1_pc0", if_pc_o, 32'h0);
      chk("t1_inst0", if_inst_o, 32'hA0);
      idle(1, 1, 32'hA4);
      chk("t1_pc1", if_pc_o, 32'h4);
      chk("t1_inst1", if_inst_o, 32'hA4);

      // Stall with two buffered instructions
      do_reset();
      idle(1, 0, 32'd0);
      idle(1, 1, 32'hB0);
      cycle(0, 0, 32'd0, 1, 1, 1, 32'hB4);
      held_pc = if_pc_o; held_inst = if_inst_o;
      chk("t2_held_pc", held_pc, 32'h0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 32'd0, 1, 1, 0, 32'd0);
      chk("t2_still_pc", if_pc_o, 32'h0);
      chk("t2_still_inst", if_inst_o, 32'hB0);
      idle(0, 0, 32'd0);
      chk("t2_next_pc", if_pc_o, 32'h4);

      // Jump with two in flight: both responses dropped
      do_reset();
      idle(1, 0, 32'd0);
      idle(1, 0, 32'd0);
      cycle(0, 1, 32'h100, 0, 1, 0, 32'd0);
      idle(0, 1, 32'hDEAD);
      idle(0, 1, 32'hBEEF);
      chk("t3_dropped", {31'd0, if_valid_o}, 32'd0);
      idle(1, 0, 32'd0);
      idle(1, 1, 32'hC100);
      chk("t3_pc_tgt", if_pc_o, 32'h100);
      idle(1, 1, 32'hC104);
      chk("t3_pc_next", if_pc_o, 32'h104);

      // Jump to unaligned target coinciding with a response
      do_reset();
      idle(1, 0, 32'd0);
      idle(1, 0, 32'd0);
      cycle(0, 1, 32'h203, 0, 1, 1, 32'h1111);
      chk("t4_req_pc", if_req_pc_o, 32'h200);
      chk("t4_dropped", {31'd0, if_valid_o}, 32'd0);
      idle(0, 1, 32'h2222);
      chk("t4_dropped2", {31'd0, if_valid_o}, 32'd0);
      idle(1, 0, 32'd0);
      idle(0, 1, 32'h3333);
      chk("t4_pc_tgt", if_pc_o, 32'h200);

      // Icache back-pressure
      do_reset();
      for (int i = 0; i < 5; i++) idle(0, 0, 32'd0);
      chk("t5_req_pc", if_req_pc_o, 32'h0);

      // Stray response and reset mid-stream
      do_reset();
      idle(0, 1, 32'h5);
      chk("t6_err", {31'd0, if_err_o}, 32'd1);
      idle(1, 0, 32'd0);
      idle(1, 1, 32'h6);
      chk("t6_err_sticky", {31'd0, if_err_o}, 32'd1);
      do_reset();
      chk("t6_err_clr", {31'd0, if_err_o}, 32'd0);
      chk("t6_req_pc", if_req_pc_o, 32'h0);
      idle(0, 1, 32'h7);
      chk("t6_err_post_rst", {31'd0, if_err_o}, 32'd1);
      do_reset();

      // Randomised traffic
      for (int i = 0; i < 4000; i++) begin
         bit r, j, st, rdy, rv;
         r   = ($urandom_range(0, 199) == 0);
         j   = ($urandom_range(0, 19) == 0);
         st  = ($urandom_range(0, 4) == 0);
         rdy = ($urandom_range(0, 9) < 7);
         rv  = (m_fl.size() != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 299) == 0);
         cycle(r, j, $urandom, st, rdy, rv, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
